fir_xifu_mem_resp: RTL and testbench
====================================

# fir_xifu_mem_resp

Core-side responder for the XIF memory interface of the FIR coprocessor. It accepts word load/store requests (`xfirlw`/`xfirsw`) issued by the coprocessor EX stage, checks alignment, forwards accepted requests to an OBI data port, and returns in-order `mem_result` pulses tagged with the instruction id. It provides the response end of the XIF memory interface, so the XIFU can be tested and integrated without a full cv32e40x LSU.

## Interface
- `ID_WIDTH`, 4: XIF instruction id width.
- `OUTSTANDING`, 2: maximum number of accepted requests without an OBI response (1..4).
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `clear_i` in 1: synchronous flush.
- `mem_valid_i` in 1: XIF memory request valid.
- `mem_ready_o` out 1: request consumed in this cycle, either accepted or rejected with an exception.
- `mem_id_i` in ID_WIDTH: instruction id.
- `mem_addr_i` in 32: byte address.
- `mem_we_i` in 1: 1 = store.
- `mem_be_i` in 4: byte enables.
- `mem_wdata_i` in 32: store data.
- `mem_resp_exc_o` out 1: exception; valid when `mem_valid_i && mem_ready_o`.
- `mem_resp_exccode_o` out 6: exception code; 4 = load misaligned, 6 = store misaligned.
- `mem_result_valid_o` out 1: single-cycle result pulse.
- `mem_result_id_o` out ID_WIDTH: id of the result.
- `mem_result_rdata_o` out 32: load data; 0 for stores.
- `mem_result_err_o` out 1: bus error for this transaction.
- `data_req_o` out 1: OBI request.
- `data_gnt_i` in 1: OBI grant.
- `data_addr_o` out 32: OBI address.
- `data_we_o` out 1: OBI write enable.
- `data_be_o` out 4: OBI byte enables.
- `data_wdata_o` out 32: OBI write data.
- `data_rvalid_i` in 1: OBI response valid.
- `data_rdata_i` in 32: OBI read data.
- `data_err_i` in 1: OBI bus error.
- `unexpected_rvalid_o` out 1: sticky flag; set by an `data_rvalid_i` with nothing outstanding and nothing to discard.

## Operation
- **Misaligned request.** `mem_addr_i[1:0] != 0` makes the request misaligned.
  - `mem_ready_o = 1` in the same cycle.
  - `mem_resp_exc_o = 1`; exccode is 6 if `mem_we_i`, else 4.
  - No OBI request is issued and no result is produced.
- **Aligned request.**
  - `data_req_o = mem_valid_i && aligned && can_push && discard_cnt == 0`.
  - `can_push` = tracking FIFO not full, or a pop happens in the same cycle.
  - OBI addr/we/be/wdata pass through combinationally from the XIF request.
  - `mem_ready_o = data_req_o && data_gnt_i`, and `mem_resp_exc_o = 0`.
  - On handshake, {id, we} is pushed into the tracking FIFO (depth OUTSTANDING).
- **Stall.** With the FIFO full and no pop, `data_req_o = 0` and `mem_ready_o = 0`. The requester holds the request.
- **Response.** On `data_rvalid_i` with `discard_cnt == 0` and the FIFO not empty:
  - The FIFO head is popped.
  - Next cycle: `mem_result_valid_o = 1`, id = head id, rdata = `we ? 0 : data_rdata_i`, err = `data_err_i`.
- **Clear.** On `clear_i`:
  - `discard_cnt` is loaded with the current occupancy, minus 1 if a pop occurs in the same cycle.
  - The FIFO is emptied and `mem_result_valid_o` is cleared next cycle.
  - A request handshake in the same cycle is not pushed, and `data_req_o` is forced 0.
- **Discard.** While `discard_cnt > 0`, each `data_rvalid_i` decrements it and produces no result. New requests are stalled until it reaches 0.
- **Unexpected response.** `data_rvalid_i` with an empty FIFO and `discard_cnt == 0` sets `unexpected_rvalid_o`. It is cleared only by `rst_i`, not by `clear_i`.
- **Ordering.** Responses are strictly in order; OBI returns responses in order.

## Timing
- Reset (`rst_i` asynchronous): FIFO empty, `discard_cnt = 0`, all result outputs 0, `unexpected_rvalid_o = 0`.
  - All combinational outputs evaluate to 0 while `mem_valid_i = 0`.
- Request-to-OBI latency: 0 cycles, combinational.
- Misaligned request: exception reported in the same cycle.
- `data_rvalid_i` to `mem_result_valid_o`: exactly 1 cycle, registered. The result lasts 1 cycle, with no backpressure.
- Push and pop in the same cycle at full occupancy: allowed, so sustained throughput is 1 transaction/cycle.
- Push and pop in the same cycle at occupancy 0 is impossible: a response needs a prior grant.
- `rst_i` mid-transaction: all state drops immediately. Responses arriving after reset raise `unexpected_rvalid_o`; the integrator must reset the bus too.

## Test plan
- **Aligned load.** Load addr 0x100, id 3; gnt same cycle; rvalid 2 cycles later with rdata 0xDEADBEEF.
  - Required: `mem_ready_o` in the request cycle.
  - Required: one cycle after rvalid, result valid with id 3, rdata 0xDEADBEEF, err 0.
- **Store, then misaligned load.** Store addr 0x204, wdata 0x12345678, id 1, then load addr 0x102, id 2.
  - Store: OBI we = 1, be = 0xF; result rdata 0.
  - Load: same-cycle exc = 1, exccode 4, no `data_req_o`.
- **Backpressure.** Three back-to-back loads (ids 0,1,2), gnt always 1, rvalid withheld.
  - Required: third request stalls with `mem_ready_o = 0`.
  - Required: the third is accepted in the first rvalid cycle, and results arrive in order 0,1,2.
- **Bus error.** Load with `data_err_i = 1` on rvalid.
  - Required: result err = 1, id matches the request.
- **Clear with outstanding work.** `clear_i` with 2 outstanding, then 2 rvalids, then a new load (id 5).
  - Required: no result pulses for the 2 dropped transactions, and `unexpected_rvalid_o` stays 0.
  - Required: the id 5 load proceeds normally.
- **Unexpected response.** rvalid after reset with nothing outstanding.
  - Required: `unexpected_rvalid_o = 1` from the next cycle, held until `rst_i`.

Source files
------------

// File: rtl/fir_xifu_mem_resp_if.sv
// XIF memory request/result channel plus OBI data port, bundled for the FIR XIFU responder.
// The slave modport is the responder; the master modport is the coprocessor/memory side.
interface fir_xifu_mem_resp_if #(
    parameter int ID_WIDTH = 4
);
    logic                mem_valid;
    logic                mem_ready;
    logic [ID_WIDTH-1:0] mem_id;
    logic [31:0]         mem_addr;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [31:0]         mem_wdata;
    logic                mem_resp_exc;
    logic [5:0]          mem_resp_exccode;
    logic                mem_result_valid;
    logic [ID_WIDTH-1:0] mem_result_id;
    logic [31:0]         mem_result_rdata;
    logic                mem_result_err;
    logic                data_req;
    logic                data_gnt;
    logic [31:0]         data_addr;
    logic                data_we;
    logic [3:0]          data_be;
    logic [31:0]         data_wdata;
    logic                data_rvalid;
    logic [31:0]         data_rdata;
    logic                data_err;

    modport slave (
        input  mem_valid, mem_id, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_ready, mem_resp_exc, mem_resp_exccode,
        output mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err,
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport master (
        output mem_valid, mem_id, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_ready, mem_resp_exc, mem_resp_exccode,
        input  mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err,
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/fir_xifu_mem_resp.sv
// Core-side responder for the FIR coprocessor XIF memory interface: alignment check,
// OBI forwarding, in-order id tracking and flush/discard of in-flight responses.
module fir_xifu_mem_resp #(
    parameter int ID_WIDTH    = 4,
    parameter int OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    fir_xifu_mem_resp_if.slave   bus,
    output logic                 unexpected_rvalid_o
);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
    localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

    logic [ID_WIDTH-1:0]    fifo_id_q [OUTSTANDING];
    logic [ID_WIDTH-1:0]    fifo_id_d [OUTSTANDING];
    logic [OUTSTANDING-1:0] fifo_we_q, fifo_we_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, discard_q, discard_d;
    logic                   res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic [ID_WIDTH-1:0]    res_id_q, res_id_d;
    logic [31:0]            res_rdata_q, res_rdata_d;
    logic                   unexp_q, unexp_d;

    logic aligned, misaligned, fifo_empty, fifo_full, discarding;
    logic pop, drop, push, can_push, deliver;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign aligned    = (bus.mem_addr[1:0] == 2'b00);
    assign misaligned = bus.mem_valid && !aligned;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign discarding = (discard_q != '0);
    assign pop        = bus.data_rvalid && !discarding && !fifo_empty;
    assign drop       = bus.data_rvalid && discarding;
    assign can_push   = !fifo_full || pop;
    assign deliver    = pop && !clear_i;

    // A flush in the same cycle blocks the request so nothing new enters the cleared FIFO.
    assign bus.data_req   = bus.mem_valid && aligned && can_push && !discarding && !clear_i;
    assign push           = bus.data_req && bus.data_gnt;
    assign bus.mem_ready  = misaligned || push;
    assign bus.mem_resp_exc     = misaligned;
    assign bus.mem_resp_exccode = misaligned ? (bus.mem_we ? EXC_STORE_MISALIGNED
                                                           : EXC_LOAD_MISALIGNED) : 6'd0;
    assign bus.data_addr  = bus.mem_valid ? bus.mem_addr  : 32'd0;
    assign bus.data_we    = bus.mem_valid && bus.mem_we;
    assign bus.data_be    = bus.mem_valid ? bus.mem_be    : 4'd0;
    assign bus.data_wdata = bus.mem_valid ? bus.mem_wdata : 32'd0;

    assign bus.mem_result_valid = res_valid_q;
    assign bus.mem_result_id    = res_id_q;
    assign bus.mem_result_rdata = res_rdata_q;
    assign bus.mem_result_err   = res_err_q;
    assign unexpected_rvalid_o  = unexp_q;

    always_comb begin
        fifo_id_d = fifo_id_q;
        fifo_we_d = fifo_we_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (push) begin
            fifo_id_d[wr_ptr_q] = bus.mem_id;
            fifo_we_d[wr_ptr_q] = bus.mem_we;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
        discard_d = discard_q - CNT_W'(drop);
        // Every request still in flight at a flush owes one response that must be swallowed.
        if (clear_i) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            discard_d = discard_q - CNT_W'(drop) + cnt_q - CNT_W'(pop);
        end

        res_valid_d = deliver;
        res_id_d    = deliver ? fifo_id_q[rd_ptr_q] : '0;
        res_rdata_d = (deliver && !fifo_we_q[rd_ptr_q]) ? bus.data_rdata : 32'd0;
        res_err_d   = deliver && bus.data_err;
        unexp_d     = unexp_q || (bus.data_rvalid && fifo_empty && !discarding);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            discard_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= 32'd0;
            res_err_q   <= 1'b0;
            unexp_q     <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
            unexp_q     <= unexp_d;
        end
    end

    // Tracking payload is only meaningful below the occupancy count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        fifo_id_q <= fifo_id_d;
        fifo_we_q <= fifo_we_d;
    end
endmodule

// File: tb/tb_fir_xifu_mem_resp.sv
// Directed bench for fir_xifu_mem_resp: load/store, misalignment, backpressure,
// bus error, flush with discard and the sticky unexpected-response flag.
module tb_fir_xifu_mem_resp;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic unexpected;
    int   n_cmp = 0;
    int   n_err = 0;

    fir_xifu_mem_resp_if #(.ID_WIDTH(4)) bus ();

    fir_xifu_mem_resp #(.ID_WIDTH(4), .OUTSTANDING(2)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .clear_i             (clear),
        .bus                 (bus),
        .unexpected_rvalid_o (unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd);
        bus.mem_valid = 1'b1;
        bus.mem_id    = id;
        bus.mem_addr  = addr;
        bus.mem_we    = we;
        bus.mem_be    = 4'hF;
        bus.mem_wdata = wd;
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.mem_id    = '0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        idle();
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_rdata  = '0;
        bus.data_err    = 1'b0;
        #1;
        chk("rst_result_valid", bus.mem_result_valid, 0);
        chk("rst_unexpected", unexpected, 0);
        chk("rst_ready", bus.mem_ready, 0);
        chk("rst_data_req", bus.data_req, 0);
        chk("rst_exc", bus.mem_resp_exc, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Aligned load, response two cycles after the grant
        req(4'd3, 32'h100, 1'b0, 32'h0);
        bus.data_gnt = 1'b1;
        settle();
        chk("ld_ready", bus.mem_ready, 1);
        chk("ld_data_req", bus.data_req, 1);
        chk("ld_data_addr", bus.data_addr, 32'h100);
        chk("ld_exc", bus.mem_resp_exc, 0);
        cyc();
        idle();
        bus.data_gnt = 1'b0;
        settle();
        cyc();
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hDEADBEEF;
        settle();
        chk("ld_res_early", bus.mem_result_valid, 0);
        cyc();
        chk("ld_res_valid", bus.mem_result_valid, 1);
        chk("ld_res_id", bus.mem_result_id, 3);
        chk("ld_res_rdata", bus.mem_result_rdata, 32'hDEADBEEF);
        chk("ld_res_err", bus.mem_result_err, 0);
        bus.data_rvalid = 1'b0;
        settle();
        cyc();
        chk("ld_res_pulse", bus.mem_result_valid, 0);

        // Store, then a misaligned load while the store response returns
        req(4'd1, 32'h204, 1'b1, 32'h12345678);
        bus.data_gnt = 1'b1;
        settle();
        chk("st_ready", bus.mem_ready, 1);
        chk("st_data_we", bus.data_we, 1);
        chk("st_data_be", bus.data_be, 4'hF);
        chk("st_data_wdata", bus.data_wdata, 32'h12345678);
        cyc();
        req(4'd2, 32'h102, 1'b0, 32'h0);
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hFFFFFFFF;
        settle();
        chk("mis_ld_exc", bus.mem_resp_exc, 1);
        chk("mis_ld_code", bus.mem_resp_exccode, 4);
        chk("mis_ld_data_req", bus.data_req, 0);
        chk("mis_ld_ready", bus.mem_ready, 1);
        cyc();
        chk("st_res_valid", bus.mem_result_valid, 1);
        chk("st_res_id", bus.mem_result_id, 1);
        chk("st_res_rdata", bus.mem_result_rdata, 0);
        bus.data_rvalid = 1'b0;
        req(4'd9, 32'h203, 1'b1, 32'h0);
        settle();
        chk("mis_st_code", bus.mem_resp_exccode, 6);
        chk("mis_st_data_req", bus.data_req, 0);
        cyc();
        chk("mis_no_result", bus.mem_result_valid, 0);

        // Backpressure: two outstanding fill the tracker, third waits for a pop
        req(4'd0, 32'h300, 1'b0, 32'h0);
        settle();
        chk("bp0_ready", bus.mem_ready, 1);
        cyc();
        req(4'd1, 32'h304, 1'b0, 32'h0);
        settle();
        chk("bp1_ready", bus.mem_ready, 1);
        cyc();
        req(4'd2, 32'h308, 1'b0, 32'h0);
        settle();
        chk("bp2_stall_ready", bus.mem_ready, 0);
        chk("bp2_stall_req", bus.data_req, 0);
        cyc();
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hA0;
        settle();
        chk("bp2_accept_ready", bus.mem_ready, 1);
        cyc();
        chk("bp_res0_id", bus.mem_result_id, 0);
        chk("bp_res0_rdata", bus.mem_result_rdata, 32'hA0);
        idle();
        bus.data_rdata = 32'hA1;
        settle();
        cyc();
        chk("bp_res1_valid", bus.mem_result_valid, 1);
        chk("bp_res1_id", bus.mem_result_id, 1);
        chk("bp_res1_rdata", bus.mem_result_rdata, 32'hA1);
        bus.data_rdata = 32'hA2;
        settle();
        cyc();
        chk("bp_res2_id", bus.mem_result_id, 2);
        chk("bp_res2_rdata", bus.mem_result_rdata, 32'hA2);
        bus.data_rvalid = 1'b0;
        settle();
        cyc();
        chk("bp_drained", bus.mem_result_valid, 0);
        chk("bp_unexpected", unexpected, 0);

        // Bus error on a load response
        req(4'd7, 32'h400, 1'b0, 32'h0);
        settle();
        cyc();
        idle();
        bus.data_rvalid = 1'b1;
        bus.data_err    = 1'b1;
        bus.data_rdata  = 32'h55;
        settle();
        cyc();
        chk("err_res_valid", bus.mem_result_valid, 1);
        chk("err_res_id", bus.mem_result_id, 7);
        chk("err_res_err", bus.mem_result_err, 1);
        bus.data_rvalid = 1'b0;
        bus.data_err    = 1'b0;

        // Flush with two outstanding; their responses must be swallowed
        req(4'd4, 32'h500, 1'b0, 32'h0);
        settle();
        cyc();
        req(4'd6, 32'h504, 1'b0, 32'h0);
        settle();
        cyc();
        idle();
        clear = 1'b1;
        settle();
        cyc();
        chk("clr_res_valid", bus.mem_result_valid, 0);
        clear = 1'b0;
        req(4'd5, 32'h600, 1'b0, 32'h0);
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'hBAD;
        settle();
        chk("clr_stall_ready", bus.mem_ready, 0);
        chk("clr_stall_req", bus.data_req, 0);
        cyc();
        chk("clr_drop0", bus.mem_result_valid, 0);
        settle();
        chk("clr_stall2_ready", bus.mem_ready, 0);
        cyc();
        chk("clr_drop1", bus.mem_result_valid, 0);
        bus.data_rvalid = 1'b0;
        settle();
        chk("clr_id5_ready", bus.mem_ready, 1);
        cyc();
        chk("clr_unexpected", unexpected, 0);
        idle();
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'h5555;
        settle();
        cyc();
        chk("clr_id5_valid", bus.mem_result_valid, 1);
        chk("clr_id5_id", bus.mem_result_id, 5);
        chk("clr_id5_rdata", bus.mem_result_rdata, 32'h5555);

        // Response with nothing outstanding sets the sticky flag
        settle();
        chk("unx_before", unexpected, 0);
        cyc();
        chk("unx_set", unexpected, 1);
        chk("unx_no_result", bus.mem_result_valid, 0);
        bus.data_rvalid = 1'b0;
        clear = 1'b1;
        settle();
        cyc();
        chk("unx_after_clear", unexpected, 1);
        clear = 1'b0;
        cyc();
        chk("unx_held", unexpected, 1);
        rst = 1'b1;
        #1;
        chk("unx_reset", unexpected, 0);
        chk("unx_reset_result", bus.mem_result_valid, 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
